write_port_arbiter: RTL

- Shares one block-RAM write port among NUM_REQ writer lanes, each carrying clipped output groups plus an address.
- Each lane has a 2-slot buffer; a round-robin scheduler grants one lane per cycle.
- The granted entry is driven as a registered write to the memory. The memory is always ready, so there is no downstream avail.
- Sits between the per-kernel output writers and the shared output block RAM.

---
 rtl/write_port_arbiter.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/write_port_arbiter.sv
// write_port_arbiter: round-robin arbiter that shares one block-RAM write port
// among NUM_REQ writer lanes. Each lane owns a 2-slot FIFO; one lane is granted
// per cycle and its head entry is issued as a registered memory write.
module write_port_arbiter #(
  parameter int NUM_REQ         = 4,
  parameter int LOG_NUM_REQ     = 2,
  parameter int DATA_WIDTH      = 16,
  parameter int LOG_MAX_ADDRESS = 16
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               clear_err,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]      req_data_in,
  input  logic [NUM_REQ*LOG_MAX_ADDRESS-1:0] req_address_in,
  input  logic [NUM_REQ-1:0]                 req_valid_in,
  output logic [NUM_REQ-1:0]                 req_avail_out,
  output logic [DATA_WIDTH-1:0]              data_out,
  output logic [LOG_MAX_ADDRESS-1:0]         address_out,
  output logic                               valid_out,
  output logic [LOG_NUM_REQ-1:0]             grant_out,
  output logic [NUM_REQ-1:0]                 overflow_out
);

  // Per-lane FIFO state
  logic [1:0]                 count_q [NUM_REQ];
  logic [1:0]                 count_d [NUM_REQ];
  logic                       head_q  [NUM_REQ];
  logic                       head_d  [NUM_REQ];
  logic                       tail_q  [NUM_REQ];
  logic                       tail_d  [NUM_REQ];
  logic [DATA_WIDTH-1:0]      data_mem_q [NUM_REQ][2];
  logic [DATA_WIDTH-1:0]      data_mem_d [NUM_REQ][2];
  logic [LOG_MAX_ADDRESS-1:0] addr_mem_q [NUM_REQ][2];
  logic [LOG_MAX_ADDRESS-1:0] addr_mem_d [NUM_REQ][2];

  // Arbitration and output state
  logic [LOG_NUM_REQ-1:0]     rr_ptr_q, rr_ptr_d;
  logic                       grant_valid;
  logic [LOG_NUM_REQ-1:0]     grant_idx;
  logic                       valid_q, valid_d;
  logic [DATA_WIDTH-1:0]      data_q, data_d;
  logic [LOG_MAX_ADDRESS-1:0] address_q, address_d;
  logic [LOG_NUM_REQ-1:0]     grant_q, grant_d;
  logic [NUM_REQ-1:0]         overflow_q, overflow_d;

  logic [NUM_REQ-1:0]         push;
  logic [NUM_REQ-1:0]         pop;
  logic [NUM_REQ-1:0]         drop;

  // Lane acceptance: a lane can take a push whenever it has a free slot
  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      req_avail_out[i] = (count_q[i] < 2'd2);
      push[i]          = req_valid_in[i] && (count_q[i] < 2'd2);
      drop[i]          = req_valid_in[i] && (count_q[i] == 2'd2);
    end
  end

  // Round-robin search starting just after the last granted lane
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      if (!grant_valid &&
          count_q[LOG_NUM_REQ'((int'(rr_ptr_q) + k) % NUM_REQ)] != 2'd0) begin
        grant_valid = 1'b1;
        grant_idx   = LOG_NUM_REQ'((int'(rr_ptr_q) + k) % NUM_REQ);
      end
    end
  end

  // FIFO next state: push at tail, pop at head, counts track both
  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      pop[i]           = grant_valid && (grant_idx == LOG_NUM_REQ'(i));
      head_d[i]        = head_q[i] ^ pop[i];
      tail_d[i]        = tail_q[i] ^ push[i];
      count_d[i]       = count_q[i] + {1'b0, push[i]} - {1'b0, pop[i]};
      data_mem_d[i][0] = data_mem_q[i][0];
      data_mem_d[i][1] = data_mem_q[i][1];
      addr_mem_d[i][0] = addr_mem_q[i][0];
      addr_mem_d[i][1] = addr_mem_q[i][1];
      if (push[i]) begin
        data_mem_d[i][tail_q[i]] = req_data_in[i*DATA_WIDTH +: DATA_WIDTH];
        addr_mem_d[i][tail_q[i]] = req_address_in[i*LOG_MAX_ADDRESS +: LOG_MAX_ADDRESS];
      end
    end
  end

  // Output register and pointer next state; outputs hold when nothing is granted
  always_comb begin
    rr_ptr_d  = rr_ptr_q;
    valid_d   = grant_valid;
    data_d    = data_q;
    address_d = address_q;
    grant_d   = grant_q;
    if (grant_valid) begin
      rr_ptr_d  = grant_idx;
      data_d    = data_mem_q[grant_idx][head_q[grant_idx]];
      address_d = addr_mem_q[grant_idx][head_q[grant_idx]];
      grant_d   = grant_idx;
    end
  end

  // Sticky overflow flags; a new overflow beats a same-cycle clear
  always_comb begin
    overflow_d = clear_err ? '0 : overflow_q;
    overflow_d = overflow_d | drop;
  end

  // Control state registers with asynchronous active-low reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        count_q[i] <= 2'd0;
        head_q[i]  <= 1'b0;
        tail_q[i]  <= 1'b0;
      end
      rr_ptr_q   <= LOG_NUM_REQ'(NUM_REQ - 1);
      valid_q    <= 1'b0;
      data_q     <= '0;
      address_q  <= '0;
      grant_q    <= '0;
      overflow_q <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        count_q[i] <= count_d[i];
        head_q[i]  <= head_d[i];
        tail_q[i]  <= tail_d[i];
      end
      rr_ptr_q   <= rr_ptr_d;
      valid_q    <= valid_d;
      data_q     <= data_d;
      address_q  <= address_d;
      grant_q    <= grant_d;
      overflow_q <= overflow_d;
    end
  end

  // Buffer storage needs no reset; counts gate every read of it
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_REQ; i++) begin
      data_mem_q[i][0] <= data_mem_d[i][0];
      data_mem_q[i][1] <= data_mem_d[i][1];
      addr_mem_q[i][0] <= addr_mem_d[i][0];
      addr_mem_q[i][1] <= addr_mem_d[i][1];
    end
  end

  assign valid_out    = valid_q;
  assign data_out     = data_q;
  assign address_out  = address_q;
  assign grant_out    = grant_q;
  assign overflow_out = overflow_q;

endmodule
